// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: command opcodes, counting modes and
// controller states.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        CMD_START    = 2'd0,
        CMD_PAUSE    = 2'd1,
        CMD_LOAD     = 2'd2,
        CMD_SET_MODE = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        MODE_UP_WRAP   = 2'd0,
        MODE_DOWN_WRAP = 2'd1,
        MODE_BOUNCE    = 2'd2,
        MODE_ONESHOT   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Prescaler register width; a divide-by-one prescaler still needs one bit.
    function automatic int prescale_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/updown_step_core.sv
// Count/direction register for the sequencer: load, step up/down, set or flip
// direction, otherwise hold. Reports the top and zero boundaries.
module updown_step_core #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step_up,
    input  logic             step_down,
    input  logic             dir_set,
    input  logic             dir_value,
    input  logic             dir_flip,
    output logic [WIDTH-1:0] count,
    output logic             direction,
    output logic             at_top,
    output logic             at_zero
);

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            direction <= 1'b0;
        end else begin
            if (load)
                count <= load_value;
            else if (step_up)
                count <= count + 1'b1;
            else if (step_down)
                count <= count - 1'b1;

            if (dir_set)
                direction <= dir_value;
            else if (dir_flip)
                direction <= ~direction;
        end
    end

    assign at_top  = &count;
    assign at_zero = ~|count;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller for a prescaled up/down counter with up-wrap,
// down-wrap, bounce and one-shot modes.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic [WIDTH-1:0] count,
    output logic             direction,
    output logic             busy,
    output logic             done,
    output logic             turn,
    output logic             cmd_err
);

    localparam int              PW      = prescale_width(PRESCALE);
    localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] TOP    = '1;

    state_t        state, state_nx;
    mode_t         mode, mode_nx;
    logic [PW-1:0] ps, ps_nx;
    logic          done_nx, turn_nx, err_nx;
    logic          running, accept, step;

    logic             ld, up, dn, dset, dval, dflip;
    logic [WIDTH-1:0] ld_val;
    logic             at_top, at_zero;

    assign cmd_ready = 1'b1;
    assign running   = (state == ST_RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = running;

    updown_step_core #(.WIDTH(WIDTH)) u_core (
        .clock      (clock),
        .reset      (reset),
        .load       (ld),
        .load_value (ld_val),
        .step_up    (up),
        .step_down  (dn),
        .dir_set    (dset),
        .dir_value  (dval),
        .dir_flip   (dflip),
        .count      (count),
        .direction  (direction),
        .at_top     (at_top),
        .at_zero    (at_zero)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        mode_nx  = mode;
        ps_nx    = ps;
        done_nx  = 1'b0;
        turn_nx  = 1'b0;
        err_nx   = 1'b0;
        ld       = 1'b0;
        ld_val   = cmd_arg;
        up       = 1'b0;
        dn       = 1'b0;
        dset     = 1'b0;
        dval     = 1'b0;
        dflip    = 1'b0;
        step     = running && (ps == PS_LAST);

        if (running)
            ps_nx = step ? '0 : ps + 1'b1;

        // Commands win over a coincident step: PAUSE cancels it, errors do not.
        if (accept) begin
            case (cmd_op_t'(cmd_op))
                CMD_START: begin
                    if (!running) begin
                        state_nx = ST_RUN;
                        ps_nx    = '0;
                        if (state == ST_DONE) begin
                            ld     = 1'b1;
                            ld_val = '0;
                            dset   = 1'b1;
                        end
                    end
                end
                CMD_PAUSE: begin
                    if (running) begin
                        state_nx = ST_PAUSED;
                        step     = 1'b0;
                        ps_nx    = ps;
                    end
                end
                CMD_LOAD: begin
                    if (running) begin
                        err_nx = 1'b1;
                    end else begin
                        ld = 1'b1;
                        if (state == ST_DONE)
                            state_nx = ST_IDLE;
                    end
                end
                CMD_SET_MODE: begin
                    if (running) begin
                        err_nx = 1'b1;
                    end else begin
                        mode_nx = mode_t'(cmd_arg[1:0]);
                        dset    = 1'b1;
                        dval    = (mode_t'(cmd_arg[1:0]) == MODE_DOWN_WRAP);
                        if (state == ST_DONE)
                            state_nx = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end

        if (step) begin
            case (mode)
                MODE_UP_WRAP:   up = 1'b1;
                MODE_DOWN_WRAP: dn = 1'b1;
                MODE_BOUNCE: begin
                    // At a boundary the count dwells for one step while turning.
                    if (!direction) begin
                        if (at_top) begin
                            dflip   = 1'b1;
                            turn_nx = 1'b1;
                        end else begin
                            up = 1'b1;
                        end
                    end else begin
                        if (at_zero) begin
                            dflip   = 1'b1;
                            turn_nx = 1'b1;
                        end else begin
                            dn = 1'b1;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    up = 1'b1;
                    if (count == TOP - 1'b1) begin
                        state_nx = ST_DONE;
                        done_nx  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            mode    <= MODE_BOUNCE;
            ps      <= '0;
            done    <= 1'b0;
            turn    <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state   <= state_nx;
            mode    <= mode_nx;
            ps      <= ps_nx;
            done    <= done_nx;
            turn    <= turn_nx;
            cmd_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: two instances (PRESCALE 1 and 3) share one
// command stream and are checked every cycle against a behavioural model.
module tb_counter_sequencer;

    localparam int TOP = 15;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
    localparam int OP_START = 0, OP_PAUSE = 1, OP_LOAD = 2, OP_SET_MODE = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_arg = 4'd0;

    logic       rdy_o  [2];
    logic [3:0] cnt_o  [2];
    logic       dir_o  [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic       turn_o [2];
    logic       err_o  [2];

    counter_sequencer #(.WIDTH(4), .PRESCALE(1)) u_dut_p1 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy_o[0]),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .count(cnt_o[0]), .direction(dir_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .turn(turn_o[0]), .cmd_err(err_o[0])
    );

    counter_sequencer #(.WIDTH(4), .PRESCALE(3)) u_dut_p3 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy_o[1]),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .count(cnt_o[1]), .direction(dir_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .turn(turn_o[1]), .cmd_err(err_o[1])
    );

    always #5 clock = ~clock;

    typedef struct {
        int st; int cnt; int dir; int mode; int pc; int done; int turn; int err;
    } mstate_t;

    mstate_t m [2];
    int      pre [2] = '{1, 3};
    int      n_checks = 0;
    int      n_pass = 0;
    bit      chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) m[i] = '{S_IDLE, 0, 0, 2, 0, 0, 0, 0};
    endfunction

    // One rising edge of the specified behaviour for instance i.
    function automatic void model_edge(input int i, input bit v, input int op, input int arg);
        mstate_t s = m[i];
        bit was_run = (s.st == S_RUN);
        bit stepping = was_run && (s.pc == pre[i] - 1);
        s.done = 0; s.turn = 0; s.err = 0;
        if (v) begin
            if (op == OP_START && !was_run) begin
                if (s.st == S_DONE) begin s.cnt = 0; s.dir = 0; end
                s.st = S_RUN; s.pc = 0;
            end else if (op == OP_PAUSE && was_run) begin
                s.st = S_PAUSED; stepping = 0;
            end else if (op == OP_LOAD || op == OP_SET_MODE) begin
                if (was_run) s.err = 1;
                else begin
                    if (op == OP_LOAD) s.cnt = arg % 16;
                    else begin s.mode = arg % 4; s.dir = (s.mode == 1) ? 1 : 0; end
                    if (s.st == S_DONE) s.st = S_IDLE;
                end
            end
        end
        if (stepping) begin
            s.pc = 0;
            case (s.mode)
                0: s.cnt = (s.cnt + 1) % 16;
                1: s.cnt = (s.cnt + 15) % 16;
                2: if (s.dir == 0) begin
                       if (s.cnt == TOP) begin s.dir = 1; s.turn = 1; end else s.cnt++;
                   end else begin
                       if (s.cnt == 0) begin s.dir = 0; s.turn = 1; end else s.cnt--;
                   end
                default: begin
                    s.cnt = (s.cnt + 1) % 16;
                    if (s.cnt == TOP) begin s.st = S_DONE; s.done = 1; end
                end
            endcase
        end else if (was_run && s.st == S_RUN) begin
            s.pc++;
        end
        m[i] = s;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("cmp%0d.count", i),     cnt_o[i],  m[i].cnt);
                check($sformatf("cmp%0d.direction", i), dir_o[i],  m[i].dir);
                check($sformatf("cmp%0d.busy", i),      busy_o[i], (m[i].st == S_RUN) ? 1 : 0);
                check($sformatf("cmp%0d.done", i),      done_o[i], m[i].done);
                check($sformatf("cmp%0d.turn", i),      turn_o[i], m[i].turn);
                check($sformatf("cmp%0d.cmd_err", i),   err_o[i],  m[i].err);
                check($sformatf("cmp%0d.cmd_ready", i), rdy_o[i],  1);
            end
        end
    end

    task automatic cycle(input bit v, input int op, input int arg);
        cmd_valid = v;
        cmd_op    = 2'(op);
        cmd_arg   = 4'(arg);
        @(posedge clock);
        for (int i = 0; i < 2; i++) model_edge(i, v, op, arg);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic cmd(input int op, input int arg);
        cycle(1'b1, op, arg);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 0);
    endtask

    initial begin
        model_reset();
        chk_en = 1'b1;
        @(negedge clock);
        check("reset.count", cnt_o[0], 0);
        check("reset.direction", dir_o[0], 0);
        check("reset.busy", busy_o[0], 0);
        check("reset.cmd_ready", rdy_o[0], 1);
        @(negedge clock);
        reset = 1'b1;

        // Default BOUNCE, PRESCALE=1: 0..15,15,14..0,0,1
        cmd(OP_START, 0);
        check("bounce.start_busy", busy_o[0], 1);
        check("bounce.start_count", cnt_o[0], 0);
        idle(15);
        check("bounce.reach_top", cnt_o[0], 15);
        idle(1);
        check("bounce.dwell_top", cnt_o[0], 15);
        check("bounce.turn_top", turn_o[0], 1);
        check("bounce.dir_down", dir_o[0], 1);
        idle(1);
        check("bounce.after_top", cnt_o[0], 14);
        idle(14);
        check("bounce.reach_zero", cnt_o[0], 0);
        idle(1);
        check("bounce.dwell_zero", cnt_o[0], 0);
        check("bounce.turn_zero", turn_o[0], 1);
        idle(1);
        check("bounce.restart_up", cnt_o[0], 1);

        // DOWN_WRAP from 2: 1,0,15,14
        cmd(OP_PAUSE, 0);
        cmd(OP_SET_MODE, 1);
        check("down.direction", dir_o[0], 1);
        cmd(OP_LOAD, 2);
        cmd(OP_START, 0);
        idle(2);
        check("down.at_zero", cnt_o[0], 0);
        idle(1);
        check("down.wrap_top", cnt_o[0], 15);
        check("down.no_turn", turn_o[0], 0);
        idle(1);
        check("down.after_wrap", cnt_o[0], 14);

        // ONESHOT from 13: 14,15 then DONE; START from DONE restarts at 0
        cmd(OP_PAUSE, 0);
        cmd(OP_SET_MODE, 3);
        cmd(OP_LOAD, 13);
        cmd(OP_START, 0);
        idle(1);
        check("oneshot.step14", cnt_o[0], 14);
        idle(1);
        check("oneshot.top", cnt_o[0], 15);
        check("oneshot.done", done_o[0], 1);
        check("oneshot.not_busy", busy_o[0], 0);
        idle(1);
        check("oneshot.done_pulse_end", done_o[0], 0);
        cmd(OP_START, 0);
        check("oneshot.restart_zero", cnt_o[0], 0);
        idle(1);
        check("oneshot.restart_one", cnt_o[0], 1);

        // Pause at 5, load 9 while paused, resume at 10
        idle(4);
        check("pause.at5", cnt_o[0], 5);
        cmd(OP_PAUSE, 0);
        idle(10);
        check("pause.held", cnt_o[0], 5);
        cmd(OP_LOAD, 9);
        check("pause.loaded", cnt_o[0], 9);
        cmd(OP_START, 0);
        idle(1);
        check("pause.resumed", cnt_o[0], 10);

        // Illegal LOAD while running: error pulse, step still happens
        cmd(OP_LOAD, 3);
        check("err.pulse", err_o[0], 1);
        check("err.stepped", cnt_o[0], 11);
        cmd(OP_START, 0);
        check("err.cleared", err_o[0], 0);
        check("err.start_noop", cnt_o[0], 12);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("areset.count", cnt_o[0], 0);
        check("areset.busy", busy_o[0], 0);
        check("areset.count_p3", cnt_o[1], 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // PRESCALE=3, UP_WRAP: steps every third edge; START restarts the phase
        cmd(OP_SET_MODE, 0);
        cmd(OP_START, 0);
        idle(2);
        check("pre3.hold", cnt_o[1], 0);
        idle(1);
        check("pre3.first_step", cnt_o[1], 1);
        idle(3);
        check("pre3.second_step", cnt_o[1], 2);
        idle(1);
        cmd(OP_PAUSE, 0);
        cmd(OP_START, 0);
        idle(2);
        check("pre3.phase_restart", cnt_o[1], 2);
        idle(1);
        check("pre3.after_restart", cnt_o[1], 3);

        // ONESHOT starting at top wraps to 0 on the first step
        cmd(OP_PAUSE, 0);
        cmd(OP_SET_MODE, 3);
        cmd(OP_LOAD, 15);
        cmd(OP_START, 0);
        idle(1);
        check("oneshot_top.wrap", cnt_o[0], 0);
        check("oneshot_top.busy", busy_o[0], 1);
        idle(3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Command-driven controller that sequences a WIDTH-bit up/down counter datapath: start, pause, load, mode select.
- Steps are paced by a prescaler. Four counting modes are supported: up-wrap, down-wrap, bounce and one-shot.
- Sits between a host/test-FSM command port and the counter. Status outputs (count, direction, busy, done, turn pulses) drive displays and downstream logic.

Parameters:
- WIDTH, 4, counter width in bits. Counter top value is 2^WIDTH-1.
- PRESCALE, 1, clock cycles per counter step (≥1). PRESCALE=1 steps on every clock.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); deassertion is used as-is.
- cmd_valid  in  1  command offered this cycle.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  0=START, 1=PAUSE, 2=LOAD, 3=SET_MODE.
- cmd_arg  in  WIDTH  LOAD: value to load. SET_MODE: bits[1:0] = mode (0 UP_WRAP, 1 DOWN_WRAP, 2 BOUNCE, 3 ONESHOT).
- count  out  WIDTH  current counter value.
- direction  out  1  0 = up, 1 = down.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when ONESHOT reaches the top.
- turn  out  1  one-cycle pulse when BOUNCE reverses direction.
- cmd_err  out  1  one-cycle pulse when a command is accepted but illegal in the current state.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, count=0, direction=0, mode=BOUNCE, prescale counter=0.
  - cmd_ready=1; busy=done=turn=cmd_err=0.
- States: IDLE, RUN, PAUSED, DONE.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid&&cmd_ready.
  - cmd_ready=1 in every state (single-cycle acceptance, no backpressure). All command effects are registered and visible after that edge.
- START:
  - IDLE/PAUSED/DONE→RUN; prescale counter cleared.
  - From DONE, count is reloaded to 0 and direction to 0 before running.
  - While in RUN, START is a no-op (no error).
- PAUSE:
  - RUN→PAUSED, holding count and direction.
  - In other states it is a no-op.
- LOAD:
  - In IDLE/PAUSED/DONE: count←cmd_arg. DONE→IDLE. direction is unchanged.
  - In RUN: ignored, cmd_err pulses.
- SET_MODE:
  - In IDLE/PAUSED/DONE: mode←cmd_arg[1:0]; direction←1 if mode=DOWN_WRAP, else 0. DONE→IDLE.
  - In RUN: ignored, cmd_err pulses.
- Prescaler:
  - In RUN, increments each clock. A step occurs on the edge where it equals PRESCALE-1, after which it clears.
  - Frozen outside RUN.
- Latency: START accepted at edge E → busy=1 after E. With PRESCALE=1 the first count change occurs at edge E+1.
- Step rules (WIDTH-bit modular arithmetic):
  - UP_WRAP: count+1; top→0.
  - DOWN_WRAP: count-1; 0→top.
  - BOUNCE, up: if count==top, direction←1 and count holds (one dwell step), turn pulses; otherwise count+1.
  - BOUNCE, down: if count==0, direction←0 and count holds, turn pulses; otherwise count-1. Resulting sequence …14,15,15,14…1,0,0,1…
  - ONESHOT: count+1. When the step produces top, the state goes to DONE with done pulsing on the same edge. If RUN begins with count==top, the first step wraps to 0.
- Simultaneous events: a command accepted on a step edge takes priority. PAUSE suppresses that step. LOAD/SET_MODE in RUN are errors, and the step still occurs.
- Reset mid-run: immediate return to reset values; pending pulses are cleared.
- Pulses (done, turn, cmd_err) are registered and high for exactly one cycle.

Decomposition:
- Package counter_seq_pkg:
  - enum cmd_op_t (START, PAUSE, LOAD, SET_MODE);
  - enum mode_t (UP_WRAP, DOWN_WRAP, BOUNCE, ONESHOT);
  - enum state_t (IDLE, RUN, PAUSED, DONE).
- Sub-module updown_step_core: the count/direction register with load, step-up, step-down, flip-direction and hold controls. It reports at_top/at_zero flags. The FSM, prescaler and command decode stay in counter_sequencer.

Test Plan:
- Reset, then START with default BOUNCE, PRESCALE=1 → count 0,1,…,15,15,14,…,0,0,1. turn pulses on the edges producing 15→15 and 0→0. direction is 1 after the first turn.
- SET_MODE arg=1, LOAD arg=2, START → count 1,0,15,14. direction=1. No turn pulses.
- SET_MODE arg=3, LOAD arg=13, START → 14,15, then DONE. done pulses once with count=15 and busy=0. A further START gives 0,1,…
- During RUN at count=5: PAUSE → count holds 5 for 10 cycles. LOAD arg=9 in PAUSED → count=9. START resumes with 10.
- LOAD arg=3 while RUN → cmd_err pulses and count keeps stepping. Drive reset=0 mid-cycle → count=0 and busy=0 immediately, without waiting for a clock edge.
- PRESCALE=3, UP_WRAP from 0 → count changes every 3rd edge. PAUSE/START restarts the prescale phase.
